// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the output collector and its FIFO.
//   AES_BLOCK_BITS  : width of one ciphertext block
//   AES_BLOCK_BYTES : bytes per block
//   collect_state_e : collector FSM state encoding
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    FLUSH   = 2'd3
  } collect_state_e;

endpackage

// File: rtl/aes_output_collector_if.sv
// -----------------------------------------------------------------------------
// aes_output_collector_if
// Valid/ready block stream from the collector to its consumer.
//   out_valid : head of the block FIFO is valid        (master -> slave)
//   out_ready : consumer takes the head this cycle     (slave  -> master)
//   out_block : head block, byte 0 in [127:120]        (master -> slave)
// -----------------------------------------------------------------------------
interface aes_output_collector_if;
  import aes_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic [AES_BLOCK_BITS-1:0] out_block;

  modport master (output out_valid, output out_block, input out_ready);
  modport slave  (input out_valid, input out_block, output out_ready);

endinterface

// File: rtl/aes_block_fifo.sv
// -----------------------------------------------------------------------------
// aes_block_fifo
// DEPTH x 128-bit synchronous FIFO. Write happens when push_i is set and the
// FIFO is not full, or is full but popped in the same cycle (the new block
// lands in the slot being freed). Read is first-word-fall-through.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write request
//   push_data_i  : block to write
//   pop_i        : remove head (ignored when empty)
//   full_o       : no free slot
//   empty_o      : no valid entry
//   head_o       : oldest entry (0 after reset)
// -----------------------------------------------------------------------------
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [AES_BLOCK_BITS-1:0] push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [AES_BLOCK_BITS-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [AES_BLOCK_BITS-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: the storage array is cleared on reset so a stale head never shows
      // on head_o; this costs a reset net per bit, acceptable at this depth.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/aes_output_collector.sv
// -----------------------------------------------------------------------------
// aes_output_collector
// Deserializes the AES core's byte stream into 128-bit blocks (byte 0 first,
// landing in [127:120]) and queues them for a valid/ready consumer. Never
// back-pressures the core: overrun and truncated windows are flagged.
//   clk, rst   : clock, synchronous active-high reset
//   aes_ready  : core ready window (17 cycles: stale byte, then bytes 0..15)
//   aes_byte   : core output byte
//   out_if     : block stream (master side)
//   drop       : 1-cycle pulse, completed block discarded (FIFO full)
//   short_err  : 1-cycle pulse, window ended before 16 bytes
//   blk_count  : blocks accepted into the FIFO, wraps at 16 bits
// drop/short_err are registered and pulse in the cycle after the event.
// -----------------------------------------------------------------------------
module aes_output_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          aes_ready,
  input  logic [7:0]                    aes_byte,
  aes_output_collector_if.master        out_if,
  output logic                          drop,
  output logic                          short_err,
  output logic [15:0]                   blk_count
);

  localparam int SHREG_BITS = AES_BLOCK_BITS - 8;

  collect_state_e          state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  // Holds bytes 0..14; byte 15 is appended on the fly when the block is pushed.
  logic [SHREG_BITS-1:0]   shreg_q, shreg_d;
  logic                    drop_q, drop_d;
  logic                    short_err_q, short_err_d;
  logic [15:0]             blk_count_q, blk_count_d;

  logic                      push_req;
  logic                      push_ok;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AES_BLOCK_BITS-1:0] push_data;
  logic [AES_BLOCK_BITS-1:0] head;

  assign push_data = {shreg_q, aes_byte};
  assign pop       = !fifo_empty && out_if.out_ready;
  assign push_ok   = push_req && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // Collector FSM, next-state and outputs.
  // IDLE consumes the stale first byte of the window, so the cycle seen in
  // SKIP already carries byte 0: it is captured there with index 0, and the
  // counter from then on holds the index of the last captured byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    push_req    = 1'b0;
    short_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aes_ready) state_d = SKIP;
      end
      SKIP: begin
        if (aes_ready) begin
          shreg_d = {shreg_q[SHREG_BITS-9:0], aes_byte};
          cnt_d   = 4'd0;
          state_d = COLLECT;
        end else begin
          short_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      COLLECT: begin
        if (aes_ready) begin
          shreg_d = {shreg_q[SHREG_BITS-9:0], aes_byte};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(AES_BLOCK_BYTES - 2)) begin
            push_req = 1'b1;
            state_d  = FLUSH;
          end
        end else begin
          short_err_d = 1'b1;
          shreg_d     = '0;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        // Extra high cycles after byte 15 are tolerated silently.
        if (!aes_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_d      = push_req && !push_ok;
  assign blk_count_d = push_ok ? blk_count_q + 16'd1 : blk_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      drop_q      <= 1'b0;
      short_err_q <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      drop_q      <= drop_d;
      short_err_q <= short_err_d;
      blk_count_q <= blk_count_d;
    end
  end

  aes_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_ok),
    .push_data_i (push_data),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Valid comes straight from registered pointers; out_ready never reaches it.
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_block = head;
  assign drop             = drop_q;
  assign short_err        = short_err_q;
  assign blk_count        = blk_count_q;

endmodule
